mips_multicycle_ctrl: RTL and testbench

- Parametrised next-generation control unit for the multicycle MIPS core; sits between the instruction register's opcode/funct fields and the Data_Path control inputs.
- Moore FSM plus ALU decoder, extended over the current controller with: a memory wait-state handshake, BEQ/BNE/ANDI/JAL support, an internal PC-enable equation and an illegal-instruction flag.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mips_alu_decoder.sv | 46 ++++
 rtl/mips_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// opcode/funct constants, ALU codes and datapath mux-select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDI_EX, S_LOGI_EX, S_IMMWB,
        S_BRANCH, S_JUMP, S_JAL, S_ILLEGAL
    } state_e;

    // Which rule the ALU decoder applies in the current state.
    typedef enum logic [2:0] {
        ALU_CLS_NONE, ALU_CLS_ADD, ALU_CLS_SUB,
        ALU_CLS_FUNCT, ALU_CLS_LOGI
    } alu_cls_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic SRCA_PC = 1'b0;
    localparam logic SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_4    = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_IMM4 = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps (state class, opcode, funct) to alu_ctl.
// Ports: i_cls, i_opcode, i_funct in; o_alu_ctl, o_funct_illegal out.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  alu_cls_e            i_cls,
    input  logic [5:0]          i_opcode,
    input  logic [5:0]          i_funct,
    output logic [ALUCTL_W-1:0] o_alu_ctl,
    output logic                o_funct_illegal
);

    logic [2:0] w_code;

    always_comb begin
        w_code          = ALU_AND;
        o_funct_illegal = 1'b0;
        case (i_cls)
            ALU_CLS_ADD: w_code = ALU_ADD;
            ALU_CLS_SUB: w_code = ALU_SUB;
            ALU_CLS_LOGI: begin
                w_code = (i_opcode == OP_ORI) ? ALU_OR : ALU_AND;
            end
            ALU_CLS_FUNCT: begin
                case (i_funct)
                    FN_ADD:  w_code = ALU_ADD;
                    FN_SUB:  w_code = ALU_SUB;
                    FN_AND:  w_code = ALU_AND;
                    FN_OR:   w_code = ALU_OR;
                    FN_SLT:  w_code = ALU_SLT;
                    // Unknown funct: EXEC writes nothing, so ADD is harmless.
                    default: begin
                        w_code          = ALU_ADD;
                        o_funct_illegal = 1'b1;
                    end
                endcase
            end
            default: w_code = ALU_AND;
        endcase
    end

    assign o_alu_ctl = ALUCTL_W'(w_code);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM with memory wait handshake,
// wait timeout, illegal-instruction pulse and ALU decoder.
// Inputs: i_clk, i_rst (async, active-low), i_opcode, i_funct, i_zero,
// i_mem_ready. Outputs: datapath controls o_*, o_illegal, o_mem_timeout.
// Macro MIPS_CTRL_PERF_EN adds o_cycle_cnt / o_instr_cnt counters.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTL_W     = 3,
    parameter int WAIT_TIMEOUT = 255
`ifdef MIPS_CTRL_PERF_EN
    ,
    parameter int PERF_W       = 32
`endif
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [5:0]          i_opcode,
    input  logic [5:0]          i_funct,
    input  logic                i_zero,
    input  logic                i_mem_ready,
    output logic                o_pc_en,
    output logic                o_iord,
    output logic                o_mem_write,
    output logic                o_ir_write,
    output logic [1:0]          o_reg_dst,
    output logic [1:0]          o_mem_to_reg,
    output logic                o_reg_write,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic                o_zext,
    output logic [1:0]          o_pc_src,
    output logic [ALUCTL_W-1:0] o_alu_ctl,
    output logic                o_illegal,
`ifdef MIPS_CTRL_PERF_EN
    output logic [PERF_W-1:0]   o_cycle_cnt,
    output logic [PERF_W-1:0]   o_instr_cnt,
`endif
    output logic                o_mem_timeout
);

    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] LP_LAST =
        CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    state_e           r_state;
    state_e           w_next;
    alu_cls_e         w_cls;
    logic             w_funct_ill;
    logic             w_waiting;
    logic             w_timeout;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_timeout;

    mips_alu_decoder #(.ALUCTL_W(ALUCTL_W)) u_alu_dec (
        .i_cls           (w_cls),
        .i_opcode        (i_opcode),
        .i_funct         (i_funct),
        .o_alu_ctl       (o_alu_ctl),
        .o_funct_illegal (w_funct_ill)
    );

    assign w_waiting = !i_mem_ready &&
        (r_state inside {S_FETCH, S_MEMRD, S_MEMWR});
    // The last waiting cycle is the one where the count would reach the limit.
    assign w_timeout = (WAIT_TIMEOUT != 0) && w_waiting &&
        (r_wait_cnt == LP_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_waiting && !w_timeout && (WAIT_TIMEOUT != 0))
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_mem_timeout <= 1'b1;
        end
    end

    assign o_mem_timeout = r_mem_timeout;

    always_comb begin
        w_cls = ALU_CLS_NONE;
        case (r_state)
            S_FETCH, S_DECODE,
            S_MEMADR, S_ADDI_EX: w_cls = ALU_CLS_ADD;
            S_BRANCH:            w_cls = ALU_CLS_SUB;
            S_EXEC:              w_cls = ALU_CLS_FUNCT;
            S_LOGI_EX:           w_cls = ALU_CLS_LOGI;
            default:             w_cls = ALU_CLS_NONE;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        o_pc_en      = 1'b0;
        o_iord       = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_dst    = DST_RT;
        o_mem_to_reg = WB_ALU;
        o_reg_write  = 1'b0;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_B;
        o_zext       = 1'b0;
        o_pc_src     = PCS_ALU;
        o_illegal    = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                o_alu_src_b = SRCB_4;
                o_ir_write  = i_mem_ready;
                o_pc_en     = i_mem_ready;
                if (i_mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM4;
                case (i_opcode)
                    OP_LW, OP_SW:    w_next = S_MEMADR;
                    OP_RTYPE:        w_next = S_EXEC;
                    OP_ADDI:         w_next = S_ADDI_EX;
                    OP_ANDI, OP_ORI: w_next = S_LOGI_EX;
                    OP_BEQ, OP_BNE:  w_next = S_BRANCH;
                    OP_J:            w_next = S_JUMP;
                    OP_JAL:          w_next = S_JAL;
                    default:         w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = SRCA_A;
                o_alu_src_b = SRCB_IMM;
                w_next = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                o_iord = 1'b1;
                if (i_mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_mem_to_reg = WB_MDR;
                o_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
                if (i_mem_ready) w_next = S_FETCH;
            end
            S_EXEC: begin
                o_alu_src_a = SRCA_A;
                w_next = w_funct_ill ? S_ILLEGAL : S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_dst   = DST_RD;
                o_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDI_EX, S_LOGI_EX: begin
                o_alu_src_a = SRCA_A;
                o_alu_src_b = SRCB_IMM;
                o_zext      = (r_state == S_LOGI_EX);
                w_next      = S_IMMWB;
            end
            S_IMMWB: begin
                o_reg_write = 1'b1;
                o_zext = (i_opcode == OP_ANDI) || (i_opcode == OP_ORI);
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = SRCA_A;
                o_pc_src    = PCS_ALUOUT;
                o_pc_en     = i_zero ^ (i_opcode == OP_BNE);
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                o_pc_src = PCS_JUMP;
                o_pc_en  = 1'b1;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                o_reg_dst    = DST_RA;
                o_mem_to_reg = WB_PC;
                o_reg_write  = 1'b1;
                o_pc_src     = PCS_JUMP;
                o_pc_en      = 1'b1;
                w_next       = S_FETCH;
            end
            S_ILLEGAL: begin
                o_illegal = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_FETCH;
    end

`ifdef MIPS_CTRL_PERF_EN
    logic [PERF_W-1:0] r_cycle_cnt;
    logic [PERF_W-1:0] r_instr_cnt;
    logic              w_retire;

    // An instruction retires when a non-fetch state hands back to FETCH,
    // except when the hand-back is a forced timeout abort.
    assign w_retire = (w_next == S_FETCH) && !w_timeout &&
        !(r_state inside {S_IDLE, S_FETCH});

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != S_IDLE) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_retire)          r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomised self-checking bench for mips_multicycle_ctrl against a
// per-instruction step model (WAIT_TIMEOUT = 4).
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_write, ir_write, reg_write;
    logic       alu_src_a, zext, illegal, mem_timeout;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [2:0] alu_ctl;

    int checks = 0;
    int errors = 0;

    logic [5:0] m_op;
    logic [5:0] m_fn;
    logic       m_zr;
    logic       exp_to = 1'b0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ALUCTL_W(3), .WAIT_TIMEOUT(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_opcode      (opcode),
        .i_funct       (funct),
        .i_zero        (zero),
        .i_mem_ready   (mem_ready),
        .o_pc_en       (pc_en),
        .o_iord        (iord),
        .o_mem_write   (mem_write),
        .o_ir_write    (ir_write),
        .o_reg_dst     (reg_dst),
        .o_mem_to_reg  (mem_to_reg),
        .o_reg_write   (reg_write),
        .o_alu_src_a   (alu_src_a),
        .o_alu_src_b   (alu_src_b),
        .o_zext        (zext),
        .o_pc_src      (pc_src),
        .o_alu_ctl     (alu_ctl),
        .o_illegal     (illegal),
        .o_mem_timeout (mem_timeout)
    );

    wire [19:0] w_obs = {pc_en, iord, mem_write, ir_write, reg_dst,
        mem_to_reg, reg_write, alu_src_a, alu_src_b, zext, pc_src,
        alu_ctl, illegal, mem_timeout};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit fn_ok(input logic [5:0] f);
        return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic logic [2:0] fn_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected control word for one cycle of the named step.
    function automatic logic [19:0] ref_ctl(input string ph, input bit rdy);
        logic pe, io, mw, irw, rw, sa, zx, il;
        logic [1:0] rd, m2r, sb, ps;
        logic [2:0] alu;
        {pe, io, mw, irw, rw, sa, zx, il} = '0;
        {rd, m2r, sb, ps} = '0;
        alu = 3'b000;
        case (ph)
            "fetch":  begin sb = 1; alu = 3'b010; pe = rdy; irw = rdy; end
            "decode": begin sb = 3; alu = 3'b010; end
            "memadr": begin sa = 1; sb = 2; alu = 3'b010; end
            "memrd":  io = 1;
            "memwb":  begin m2r = 1; rw = 1; end
            "memwr":  begin io = 1; mw = 1; end
            "exec":   begin sa = 1; alu = fn_alu(m_fn); end
            "aluwb":  begin rd = 1; rw = 1; end
            "addi":   begin sa = 1; sb = 2; alu = 3'b010; end
            "logi":   begin
                sa = 1; sb = 2; zx = 1;
                alu = (m_op == 6'h0C) ? 3'b000 : 3'b001;
            end
            "immwb":  begin rw = 1; zx = (m_op == 6'h0C) || (m_op == 6'h0D); end
            "branch": begin
                sa = 1; alu = 3'b110; ps = 1;
                pe = (m_op == 6'h04) ? m_zr : !m_zr;
            end
            "jump":   begin ps = 2; pe = 1; end
            "jal":    begin rd = 2; m2r = 2; rw = 1; ps = 2; pe = 1; end
            "illegal": il = 1;
            default: ;
        endcase
        return {pe, io, mw, irw, rd, m2r, rw, sa, sb, zx, ps, alu, il, exp_to};
    endfunction

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input string ph, input bit rdy);
        mem_ready = rdy;
        #1;
        chk(ph, 32'(w_obs), 32'(ref_ctl(ph, rdy)));
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f,
                             input bit z);
        m_op = o; m_fn = f; m_zr = z;
        opcode = o; funct = f; zero = z;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input bit z, input int wf, input int wm);
        set_instr(o, f, z);
        repeat (wf) step("fetch", 1'b0);
        step("fetch", 1'b1);
        step("decode", rnd());
        case (o)
            6'h23: begin
                step("memadr", rnd());
                repeat (wm) step("memrd", 1'b0);
                step("memrd", 1'b1);
                step("memwb", rnd());
            end
            6'h2B: begin
                step("memadr", rnd());
                repeat (wm) step("memwr", 1'b0);
                step("memwr", 1'b1);
            end
            6'h00: begin
                step("exec", rnd());
                step(fn_ok(f) ? "aluwb" : "illegal", rnd());
            end
            6'h08: begin step("addi", rnd()); step("immwb", rnd()); end
            6'h0C, 6'h0D: begin step("logi", rnd()); step("immwb", rnd()); end
            6'h04, 6'h05: step("branch", rnd());
            6'h02: step("jump", rnd());
            6'h03: step("jal", rnd());
            default: step("illegal", rnd());
        endcase
    endtask

    task automatic run_random(input int n);
        logic [5:0] ops [11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [5:0] o, f;
        for (int i = 0; i < n; i++) begin
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) :
                ops[$urandom_range(0, 10)];
            f = ($urandom_range(0, 5) == 0) ? 6'($urandom) :
                fns[$urandom_range(0, 4)];
            run_instr(o, f, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst = 1'b0;
        #12;
        chk("reset", 32'(w_obs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step("idle", rnd());

        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);
        run_instr(6'h04, 6'h00, 1'b1, 1, 0);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h3F, 1'b0, 0, 0);
        run_instr(6'h0C, 6'h00, 1'b0, 2, 0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0);

        // SW with memory stuck: four write cycles then forced refetch.
        set_instr(6'h2B, 6'h00, 1'b0);
        step("fetch", 1'b1);
        step("decode", 1'b0);
        step("memadr", 1'b0);
        repeat (4) step("memwr", 1'b0);
        exp_to = 1'b1;
        step("fetch", 1'b0);
        run_instr(6'h00, 6'h22, 1'b0, 0, 0);

        // Async reset in the middle of a waiting write.
        set_instr(6'h2B, 6'h00, 1'b0);
        step("fetch", 1'b1);
        step("decode", 1'b0);
        step("memadr", 1'b0);
        step("memwr", 1'b0);
        mem_ready = 1'b0;
        #2;
        rst = 1'b0;
        exp_to = 1'b0;
        #1;
        chk("rst_async", 32'(w_obs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step("idle", rnd());

        run_random(200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
